// File: rtl/race_pkg.sv
// race_pkg: shared state encoding, widths and helpers for the race sequencer.
// RACE_PAUSE_EN widens the state code to 3 bits and adds ST_PAUSE.
package race_pkg;

`ifdef RACE_PAUSE_EN
   localparam int STATE_W = 3;
`else
   localparam int STATE_W = 2;
`endif

   localparam int COUNTDOWN_STEPS = 3;
   localparam int TIME_W          = 16;
   localparam int LAP_W           = 4;
   localparam int POS_W           = 11;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = STATE_W'(0),
      ST_COUNTDOWN = STATE_W'(1),
      ST_RACE      = STATE_W'(2),
`ifdef RACE_PAUSE_EN
      ST_FINISH    = STATE_W'(3),
      ST_PAUSE     = STATE_W'(4)
`else
      ST_FINISH    = STATE_W'(3)
`endif
   } state_t;

   function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
      return (&v) ? v : v + TIME_W'(1);
   endfunction

endpackage

// File: rtl/race_sequencer_box_hit.sv
// box_hit: inclusive rectangle test on the car position, registered once,
// plus a one-cycle pulse on the registered entry into the box.
module box_hit
   import race_pkg::*;
#(
   parameter int X0 = 1,
   parameter int X1 = 2,
   parameter int Y0 = 1,
   parameter int Y1 = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [POS_W-1:0] xpos,
   input  logic [POS_W-1:0] ypos,
   output logic             hit,
   output logic             rise
);

   logic in_box;
   logic hit_d;

   assign in_box = (xpos >= POS_W'(X0)) && (xpos <= POS_W'(X1)) &&
                   (ypos >= POS_W'(Y0)) && (ypos <= POS_W'(Y1));

   // Register the compare and keep last cycle's value for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit   <= 1'b0;
         hit_d <= 1'b0;
      end else begin
         hit   <= in_box;
         hit_d <= hit;
      end
   end

   assign rise = hit & ~hit_d;

endmodule

// File: rtl/race_sequencer.sv
// race_sequencer: game-level FSM for countdown, lap counting, race timer and
// layer enables. Optional pause state behind RACE_PAUSE_EN.
module race_sequencer
   import race_pkg::*;
#(
   parameter int FPS    = 60,
   parameter int LAPS   = 3,
   parameter int FIN_X0 = 448,
   parameter int FIN_X1 = 575,
   parameter int FIN_Y0 = 600,
   parameter int FIN_Y1 = 615,
   parameter int CHK_X0 = 448,
   parameter int CHK_X1 = 575,
   parameter int CHK_Y0 = 100,
   parameter int CHK_Y1 = 115
) (
   input  logic               pclk,
   input  logic               rst,
   input  logic               frame_ended,
   input  logic               start_key,
`ifdef RACE_PAUSE_EN
   input  logic               pause_key,
`endif
   input  logic [10:0]        xpos,
   input  logic [10:0]        ypos,
   output logic               bg_visible,
   output logic               track_visible,
   output logic               player_visible,
   output logic               car_enable,
   output logic [STATE_W-1:0] state,
   output logic [1:0]         countdown,
   output logic [LAP_W-1:0]   lap_count,
   output logic [TIME_W-1:0]  race_time
);

   localparam int FRM_W = (FPS > 1) ? $clog2(FPS) : 1;

   state_t            st_q;
   state_t            st_n;
   logic [FRM_W-1:0]  frm_q;
   logic [FRM_W-1:0]  frm_n;
   logic [1:0]        cd_n;
   logic [LAP_W-1:0]  lap_n;
   logic [LAP_W-1:0]  lap_inc;
   logic [TIME_W-1:0] rt_n;
   logic              chk_q;
   logic              chk_n;
   logic              trk_n;
   logic              car_n;

   // Holds "key was low last cycle"; clears on reset so a held key is not a press.
   logic              key_rel_q;
   logic              press;

   logic              chk_hit;
   logic              chk_rise;
   logic              fin_hit;
   logic              fin_rise;
   logic              lap_done;
   logic              unused_hits;

`ifdef RACE_PAUSE_EN
   logic              pause_rel_q;
   logic              pause_press;
   assign pause_press = pause_key & pause_rel_q;
`endif

   assign press       = start_key & key_rel_q;
   assign lap_inc     = lap_count + LAP_W'(1);
   assign lap_done    = fin_rise & chk_q;
   assign unused_hits = chk_rise ^ fin_hit;
   assign state       = st_q;

   box_hit #(
      .X0 (CHK_X0),
      .X1 (CHK_X1),
      .Y0 (CHK_Y0),
      .Y1 (CHK_Y1)
   ) u_chk (
      .clk  (pclk),
      .rst  (rst),
      .xpos (xpos),
      .ypos (ypos),
      .hit  (chk_hit),
      .rise (chk_rise)
   );

   box_hit #(
      .X0 (FIN_X0),
      .X1 (FIN_X1),
      .Y0 (FIN_Y0),
      .Y1 (FIN_Y1)
   ) u_fin (
      .clk  (pclk),
      .rst  (rst),
      .xpos (xpos),
      .ypos (ypos),
      .hit  (fin_hit),
      .rise (fin_rise)
   );

   // State, counters and registered outputs.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         st_q           <= ST_IDLE;
         bg_visible     <= 1'b1;
         track_visible  <= 1'b0;
         player_visible <= 1'b0;
         car_enable     <= 1'b0;
         countdown      <= 2'd0;
         lap_count      <= '0;
         race_time      <= '0;
         chk_q          <= 1'b0;
         key_rel_q      <= 1'b0;
         frm_q          <= '0;
`ifdef RACE_PAUSE_EN
         pause_rel_q    <= 1'b0;
`endif
      end else begin
         st_q           <= st_n;
         bg_visible     <= 1'b1;
         track_visible  <= trk_n;
         player_visible <= trk_n;
         car_enable     <= car_n;
         countdown      <= cd_n;
         lap_count      <= lap_n;
         race_time      <= rt_n;
         chk_q          <= chk_n;
         key_rel_q      <= ~start_key;
         frm_q          <= frm_n;
`ifdef RACE_PAUSE_EN
         pause_rel_q    <= ~pause_key;
`endif
      end
   end

   // Next-state and next-value logic for the whole sequencer.
   always_comb begin
      st_n  = st_q;
      cd_n  = countdown;
      frm_n = frm_q;
      lap_n = lap_count;
      rt_n  = race_time;
      chk_n = chk_q;
      unique case (st_q)
         ST_IDLE: begin
            if (press) begin
               st_n  = ST_COUNTDOWN;
               cd_n  = 2'(COUNTDOWN_STEPS);
               frm_n = '0;
               lap_n = '0;
               rt_n  = '0;
               chk_n = 1'b0;
            end
         end
         ST_COUNTDOWN: begin
            if (frame_ended) begin
               if (frm_q == FRM_W'(FPS - 1)) begin
                  frm_n = '0;
                  if (countdown == 2'd1) begin
                     cd_n = 2'd0;
                     st_n = ST_RACE;
                  end else begin
                     cd_n = countdown - 2'd1;
                  end
               end else begin
                  frm_n = frm_q + FRM_W'(1);
               end
            end
         end
         ST_RACE: begin
            if (chk_hit) begin
               chk_n = 1'b1;
            end
            // Finish test uses the flag as it was before this cycle's set.
            if (lap_done) begin
               lap_n = lap_inc;
               chk_n = 1'b0;
            end
            if (lap_done && (lap_inc == LAP_W'(LAPS))) begin
               st_n = ST_FINISH;
            end else begin
               if (frame_ended) begin
                  rt_n = sat_inc(race_time);
               end
`ifdef RACE_PAUSE_EN
               if (pause_press) begin
                  st_n = ST_PAUSE;
               end
`endif
            end
         end
         ST_FINISH: begin
            if (press) begin
               st_n = ST_IDLE;
            end
         end
`ifdef RACE_PAUSE_EN
         ST_PAUSE: begin
            if (press) begin
               st_n = ST_IDLE;
            end else if (pause_press) begin
               st_n = ST_RACE;
            end
         end
`endif
         default: begin
            st_n = ST_IDLE;
         end
      endcase
      trk_n = (st_n != ST_IDLE);
      car_n = (st_n == ST_RACE);
   end

endmodule
